// File: rtl/mic3_sampler.sv
`default_nettype none
// ============================================================================
// Module   : mic3_sampler
// Purpose  : Periodic and single-shot conversion scheduler for the Pmod MIC3
//            interface. Provides a valid/ready sample output and a decaying peak.
// Revision : 1.0 - initial release
// ============================================================================
module mic3_sampler #(
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 64,
    parameter int TIMEOUT    = 256,
    parameter int DECAY_SH   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                single,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear_flags,
    output logic                mic_read,
    input  logic [11:0]         mic_audio,
    input  logic                mic_new_data,
    output logic [11:0]         sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [11:0]         peak,
    output logic                overrun,
    output logic                timeout_err,
    output logic                busy
);

    localparam int                  WAIT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PERIOD_W-1:0] C_MIN_P     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] C_P_ONE     = PERIOD_W'(1);
    localparam logic [WAIT_W-1:0]   C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]   C_WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_enable_d;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic                r_pending;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [11:0]         r_sample;
    logic                r_valid;
    logic [11:0]         r_peak;
    logic                r_overrun;
    logic                r_timeout;
    logic [PERIOD_W-1:0] w_p_eff;
    logic                w_timer_req;
    logic                w_capture;
    logic                w_timeout;
    logic                w_tick;

    assign w_p_eff     = (period < C_MIN_P) ? C_MIN_P : period;
    assign w_timer_req = (enable & ~r_enable_d) | (enable & (r_period_cnt == '0));

    // Period timer: a rising enable or an expired count both fire and reload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable_d   <= 1'b0;
            r_period_cnt <= '0;
        end else begin
            r_enable_d <= enable;
            if (w_timer_req)
                r_period_cnt <= w_p_eff - C_P_ONE;
            else if (enable)
                r_period_cnt <= r_period_cnt - C_P_ONE;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: if (r_pending) w_state_nxt = ST_REQ;
            ST_REQ:  w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mic_new_data) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Requests seen while the REQ cycle consumes the pending flag are merged away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pending  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_state == ST_REQ) ? 1'b0 : (r_pending | single | w_timer_req);
            if (r_state == ST_REQ)
                r_wait_cnt <= '0;
            else if (r_state == ST_WAIT)
                r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;
        end
    end

    generate
        if (DECAY_SH > 0) begin : g_decay_cnt
            logic [DECAY_SH-1:0] r_decay_cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    r_decay_cnt <= '0;
                else
                    r_decay_cnt <= r_decay_cnt + DECAY_SH'(1);
            end
            assign w_tick = &r_decay_cnt;
        end else begin : g_decay_every
            assign w_tick = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_peak    <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_capture) begin
                r_sample <= mic_audio;
                r_valid  <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end

            if (w_capture && r_valid && !sample_ready)
                r_overrun <= 1'b1;
            else if (clear_flags)
                r_overrun <= 1'b0;

            if (w_timeout)
                r_timeout <= 1'b1;
            else if (clear_flags)
                r_timeout <= 1'b0;

            // A larger capture beats a coincident decay tick.
            if (w_capture && (mic_audio > r_peak))
                r_peak <= mic_audio;
            else if (w_tick && (r_peak != 12'd0))
                r_peak <= r_peak - 12'd1;
        end
    end

    assign mic_read     = (r_state == ST_REQ);
    assign busy         = (r_state != ST_IDLE);
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign peak         = r_peak;
    assign overrun      = r_overrun;
    assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mic3_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mic3_sampler
// Purpose  : Self-checking bench for mic3_sampler: directed tables/sequences
//            plus random stimulus against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mic3_sampler;

    localparam int MIN_P = 64;
    localparam int TOUT  = 256;
    localparam int DSH   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        single;
    logic [15:0] period;
    logic        clear_flags;
    logic        mic_read;
    logic [11:0] mic_audio;
    logic        mic_new_data;
    logic [11:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic [11:0] peak;
    logic        overrun;
    logic        timeout_err;
    logic        busy;

    always #5 clk = ~clk;

    mic3_sampler #(
        .PERIOD_W  (16),
        .MIN_PERIOD(MIN_P),
        .TIMEOUT   (TOUT),
        .DECAY_SH  (DSH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .single      (single),
        .period      (period),
        .clear_flags (clear_flags),
        .mic_read    (mic_read),
        .mic_audio   (mic_audio),
        .mic_new_data(mic_new_data),
        .sample      (sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .peak        (peak),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: time-stamped view of conversions (edge index since reset).
    int        m_cyc;
    bit        m_en_prev;
    int        m_fire_at;
    bit        m_pend;
    bit        m_active;
    int        m_r;
    bit        m_read;
    bit [11:0] m_sample;
    bit [11:0] m_peak;
    bit        m_valid;
    bit        m_ovr;
    bit        m_to;

    // Mic responder state
    bit        auto_resp = 1'b0;
    bit        spur      = 1'b0;
    int        resp_delay = 5;
    int        resp_cnt   = 0;

    function automatic void model_reset();
        m_cyc = 0; m_en_prev = 1'b0; m_fire_at = 0; m_pend = 1'b0;
        m_active = 1'b0; m_r = 0; m_read = 1'b0; m_sample = '0; m_peak = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
    endfunction

    function automatic void model_step();
        int n        = m_cyc;
        bit was_act  = m_active;
        int was_r    = m_r;
        bit was_pend = m_pend;
        bit fire     = 1'b0;
        bit cap      = 1'b0;
        bit tout     = 1'b0;
        bit dtick;
        int peff;
        peff  = (int'(period) < MIN_P) ? MIN_P : int'(period);
        dtick = (n % (1 << DSH)) == ((1 << DSH) - 1);
        if (enable && (!m_en_prev || n == m_fire_at)) begin
            fire      = 1'b1;
            m_fire_at = n + peff;
        end
        m_en_prev = enable;
        if (was_act) begin
            if (n >= was_r + 2 && mic_new_data) begin
                cap = 1'b1; m_active = 1'b0;
            end else if (n == was_r + 1 + TOUT) begin
                tout = 1'b1; m_active = 1'b0;
            end
        end else if (was_pend) begin
            m_active = 1'b1; m_r = n;
        end
        m_pend = (was_act && n == was_r + 1) ? 1'b0 : (was_pend | single | fire);
        if (cap && m_valid && !sample_ready) m_ovr = 1'b1;
        else if (clear_flags)                m_ovr = 1'b0;
        if (tout)             m_to = 1'b1;
        else if (clear_flags) m_to = 1'b0;
        if (cap && mic_audio > m_peak) m_peak = mic_audio;
        else if (dtick && m_peak != 0) m_peak = m_peak - 12'd1;
        if (cap) begin
            m_sample = mic_audio; m_valid = 1'b1;
        end else if (m_valid && sample_ready) begin
            m_valid = 1'b0;
        end
        m_read = m_active && (m_r == n);
        m_cyc  = n + 1;
    endfunction

    function automatic logic [28:0] act_vec();
        return {mic_read, sample, sample_valid, peak, overrun, timeout_err, busy};
    endfunction

    function automatic logic [28:0] exp_vec();
        return {m_read, m_sample, m_valid, m_peak, m_ovr, m_to, m_active};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (auto_resp) begin
            mic_new_data = spur;
            mic_audio    = 12'($urandom);
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) mic_new_data = 1'b1;
            end
        end
        @(posedge clk);
        model_step();
        #1;
        check("cycle_model", 32'(act_vec()), 32'(exp_vec()));
        if (auto_resp && mic_read) resp_cnt = resp_delay;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; single = 1'b0; enable = 1'b0; mic_new_data = 1'b0;
        clear_flags = 1'b0; resp_cnt = 0; spur = 1'b0;
        #1;
        model_reset();
        check("reset_outputs", 32'(act_vec()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (mic_read) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_read: no mic_read within 400 cycles, got 0 expected 1");
        end
    endtask

    task automatic convert(input logic [11:0] a, input int d);
        bit ok;
        single = 1'b1; tick(); single = 1'b0;
        wait_read(ok);
        repeat (d - 1) tick();
        mic_new_data = 1'b1; mic_audio = a; tick(); mic_new_data = 1'b0;
    endtask

    typedef struct {
        logic [15:0] per;
        int          gap;
    } per_vec_t;

    per_vec_t ptab [6];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;
        int reads;

        ptab[0] = '{16'd100, 100};
        ptab[1] = '{16'd10,  64};
        ptab[2] = '{16'd64,  64};
        ptab[3] = '{16'd63,  64};
        ptab[4] = '{16'd65,  65};
        ptab[5] = '{16'd0,   64};

        rst = 1'b1; enable = 1'b0; single = 1'b0; period = 16'd100;
        clear_flags = 1'b0; mic_audio = '0; mic_new_data = 1'b0; sample_ready = 1'b0;
        model_reset();
        do_reset();

        // Single shot, mic answers 30 cycles after the read pulse
        single = 1'b1; tick(); single = 1'b0;
        check("single_e0", {30'd0, mic_read, busy}, 32'b00);
        tick();
        check("single_e1_read", {30'd0, mic_read, busy}, 32'b11);
        repeat (29) tick();
        check("single_waiting", {30'd0, mic_read, busy}, 32'b01);
        mic_new_data = 1'b1; mic_audio = 12'hABC; tick(); mic_new_data = 1'b0;
        check("abc_sample", 32'(sample), 32'hABC);
        check("abc_valid_busy", {30'd0, sample_valid, busy}, 32'b10);
        check("abc_peak", 32'(peak), 32'hABC);
        repeat (3) tick();
        check("abc_hold_valid", 32'(sample_valid), 32'd1);
        sample_ready = 1'b1; tick(); sample_ready = 1'b0;
        check("abc_consumed", 32'(sample_valid), 32'd0);

        // Period clamp table
        foreach (ptab[k]) begin
            do_reset();
            auto_resp = 1'b1; resp_delay = 5;
            period = ptab[k].per; enable = 1'b1;
            wait_read(ok);
            cnt = 0;
            for (int i = 0; i < 400; i++) begin
                tick();
                cnt++;
                if (mic_read) break;
            end
            check($sformatf("period_gap_%0d", ptab[k].per), 32'(cnt), 32'(ptab[k].gap));
            enable = 1'b0; auto_resp = 1'b0; mic_new_data = 1'b0;
            repeat (10) tick();
        end

        // Overrun and clear
        do_reset();
        sample_ready = 1'b0;
        convert(12'h100, 5);
        check("ovr_first", {19'd0, overrun, sample}, {19'd0, 1'b0, 12'h100});
        convert(12'h200, 5);
        check("ovr_second", {18'd0, overrun, sample_valid, sample}, {18'd0, 2'b11, 12'h200});
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Timeout exactly TOUT cycles after entering WAIT
        single = 1'b1; tick(); single = 1'b0;
        wait_read(ok);
        repeat (TOUT) tick();
        check("to_before", {30'd0, timeout_err, busy}, 32'b01);
        tick();
        check("to_after", {29'd0, timeout_err, busy, sample_valid}, 32'b101);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        check("to_cleared", 32'(timeout_err), 32'd0);

        // Peak decay: one step per 4 cycles down to zero
        do_reset();
        sample_ready = 1'b1;
        convert(12'h010, 3);
        check("decay_start", 32'(peak), 32'h010);
        for (int k = 1; k <= 16; k++) begin
            repeat (4) tick();
            check("decay_step", 32'(peak), 32'(16 - k));
        end
        repeat (8) tick();
        check("decay_floor", 32'(peak), 32'd0);
        convert(12'h008, 3);
        check("peak_8", 32'(peak), 32'h008);
        convert(12'h005, 3);
        check("peak_no_raise", {31'd0, (peak > 12'd5) && (peak <= 12'd8)}, 32'd1);

        // Reset mid-WAIT, then a late strobe
        single = 1'b1; tick(); single = 1'b0;
        wait_read(ok);
        repeat (5) tick();
        do_reset();
        mic_new_data = 1'b1; mic_audio = 12'hFFF; tick(); mic_new_data = 1'b0;
        check("late_strobe", 32'(act_vec()), 32'd0);

        // Requests while busy: served once afterwards, extra pulse merged
        sample_ready = 1'b1; auto_resp = 1'b1; resp_delay = 20;
        reads = 0;
        for (int i = 0; i < 200; i++) begin
            single = (i == 0) || (i == 6) || (i == 11);
            tick();
            if (mic_read) reads++;
        end
        single = 1'b0;
        check("merge_reads", 32'(reads), 32'd2);

        // Randomized traffic against the model
        do_reset();
        period = 16'd100;
        for (int i = 0; i < 4000; i++) begin
            single       = ($urandom % 40) == 0;
            sample_ready = ($urandom % 3) != 0;
            clear_flags  = ($urandom % 50) == 0;
            spur         = ($urandom % 60) == 0;
            resp_delay   = (($urandom % 20) == 0) ? 0 : int'($urandom_range(1, 50));
            if (($urandom % 300) == 0) enable = ~enable;
            if (($urandom % 500) == 0) period = 16'($urandom_range(0, 130));
            if (($urandom % 1500) == 0) do_reset();
            tick();
        end
        auto_resp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mic3_sampler.md
# mic3_sampler

Sampling controller that sits between the Pmod MIC3 SPI interface (`mic3`) and audio consumers such as the LED level meter. It schedules conversions at a programmable sample period or on single-shot requests, drives the interface's `read` input, captures each 12-bit result, and presents it through a valid/ready handshake. It also maintains a decaying peak level and reports overrun and timeout errors.

## Interface
Parameters:
- `PERIOD_W`, 16: width of `period`.
- `MIN_PERIOD`, 64: smallest effective sample period in clk cycles; covers one full `mic3` SPI transaction.
- `TIMEOUT`, 256: cycles in WAIT without `mic_new_data` before the attempt is abandoned.
- `DECAY_SH`, 10: the peak decays by 1 every 2^DECAY_SH cycles.

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous reset, active-low.
- `enable` in 1: periodic sampling on.
- `single` in 1: one-cycle single-shot request (debounced upstream).
- `period` in PERIOD_W: sample period in clk cycles.
- `clear_flags` in 1: clears `overrun` and `timeout_err`.
- `mic_read` out 1: to `mic3` read; one-cycle pulse per conversion.
- `mic_audio` in 12: `mic3` audio output.
- `mic_new_data` in 1: `mic3` one-cycle strobe, high when `mic_audio` is valid.
- `sample` out 12: last captured sample.
- `sample_valid` out 1: `sample` unconsumed.
- `sample_ready` in 1: consumer accepts `sample`.
- `peak` out 12: decaying peak of captured samples.
- `overrun` out 1: sticky; a sample was overwritten unconsumed.
- `timeout_err` out 1: sticky; a conversion timed out.
- `busy` out 1: FSM not in IDLE.

## Operation
- Reset (`rst`=0, asynchronous): FSM=IDLE, all outputs 0, `pending`=0, period counter=0, decay counter=0.
- Effective period: `p_eff` = max(`period`, MIN_PERIOD). It is sampled at each counter reload.
- Period timer:
  - On a rising `enable` (registered edge detect), raise a request and load the counter with `p_eff`-1.
  - While `enable`=1, the counter decrements each cycle. At 0 it raises a request and reloads.
  - While `enable`=0, the counter holds.
- Request sources are `single` and the timer. Any request sets the one-deep `pending` flag. Requests arriving while `pending`=1 are merged (dropped).
- FSM states:
  - IDLE: if `pending`, go to REQ.
  - REQ: `mic_read`=1 for this cycle only. Clear `pending`, clear the wait counter, go to WAIT.
  - WAIT: on `mic_new_data`, capture and go to IDLE. If the wait counter reaches TIMEOUT-1 without `mic_new_data`, set `timeout_err` and go to IDLE with no capture.
- `mic_new_data` in IDLE or REQ is ignored: no capture, no flag.
- Capture:
  - `sample` <= `mic_audio`; `sample_valid` <= 1.
  - If `sample_valid`=1 and `sample_ready`=0 in the capture cycle, set `overrun`. The new sample still overwrites.
- Handshake: `sample_valid` clears on a cycle with `sample_valid`&`sample_ready` and no capture. Capture and consume in the same cycle leaves `sample_valid`=1 with no overrun.
- Peak:
  - At capture, if `mic_audio` > `peak`, then `peak` <= `mic_audio`.
  - Otherwise, on each decay tick, `peak` decrements and saturates at 0.
  - When a capture and a decay tick coincide, a larger capture wins. A non-larger capture still lets the decay apply.
- Flags: `clear_flags` clears both sticky flags. A set event in the same cycle wins.
- `busy` = (state != IDLE).

## Timing
- `single` high at edge E0 gives `pending`=1 after E0, REQ after E1, and `mic_read` high for exactly the one cycle between E1 and E2.
- `mic_new_data` high at edge Ek gives `sample`, `sample_valid` and `peak` updated after Ek, with the FSM in IDLE after Ek.
- Periodic mode: `mic_read` pulses are exactly `p_eff` cycles apart, provided each conversion finishes within `p_eff`-2 cycles.
- Timeout: the attempt is abandoned exactly TIMEOUT cycles after entering WAIT.
- Deassertion of `enable` mid-conversion does not abort the conversion; an already-pending request is still served.
- Reset mid-conversion returns the FSM to IDLE immediately. Any `mic3` strobe arriving after reset is ignored.

## Test plan
- `single` pulse, `mic3` model returns 0xABC 30 cycles after `mic_read` -> one `mic_read` pulse 2 cycles after the request; `sample`=0xABC; `sample_valid`=1 until `sample_ready`; `peak`=0xABC.
- `enable`=1, `period`=100 -> `mic_read` pulses every 100 cycles; `period`=10 -> pulses every 64 cycles (clamped to MIN_PERIOD).
- `sample_ready`=0, two captures 0x100 then 0x200 -> `sample`=0x200, `overrun`=1; `clear_flags` -> `overrun`=0.
- No `mic_new_data` after `mic_read` -> `timeout_err`=1 exactly 256 cycles after entering WAIT, FSM back in IDLE, `sample_valid` unchanged.
- Capture 0x010 with `DECAY_SH`=2 -> `peak` decreases by 1 every 4 cycles down to 0; a capture of 0x005 at 0x008 does not raise `peak`.
- `rst` low during WAIT, then a late `mic_new_data` -> all outputs 0 and no capture; `single` pulse while `busy` -> served after the current conversion, and a second pulse during the same busy period is merged.
